dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single data memory between requester 0 (CPU load/store path) and requester 1 (peripheral/DMA engine).
- Round-robin arbitration with an optional locked burst for atomic sequences; a forced release after MAX_BURST beats bounds starvation.
- Registered one-cycle response (rvalid/rdata/err) per accepted transfer.
- Illegal or misaligned addresses are blocked from memory and return an error response.

---
 rtl/dmem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between two requesters.
//   rq0 = CPU load/store path, rq1 = peripheral/DMA engine.
//   Arbitration is round-robin. A requester can hold a locked burst for
//   atomic sequences. The lock is forced off after MAX_BURST accepted beats.
//   Each accepted transfer gets a registered one-cycle response
//   (rvalid/rdata/err). Illegal or misaligned addresses never reach memory;
//   they return err = 1.
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   rqN_req/wr/lock        request, write flag, keep-ownership flag
//   rqN_addr/wdata         byte address and write data
//   rqN_gnt                combinational grant; accepted when req & gnt
//   rqN_rvalid/rdata/err   registered response, one cycle after acceptance
//   mem_rd/wr/addr/wdata   memory strobes and payload (0 when idle)
//   mem_rdata              combinational read data from the memory
module dmem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rq0_req,
  input  logic              rq0_wr,
  input  logic              rq0_lock,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic              rq1_req,
  input  logic              rq1_wr,
  input  logic              rq1_lock,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq0_gnt,
  output logic              rq0_rvalid,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic              rq0_err,
  output logic              rq1_gnt,
  output logic              rq1_rvalid,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              rq1_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} mode_e;

  mode_e              mode_q, mode_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic               err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic               gnt0, gnt1, accept, win;
  logic               owner_busy;
  logic               win_wr, win_lock, legal;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  // Grant selection; reset gates everything so no strobe leaks out during reset.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    // The lock only holds while the owner keeps requesting; otherwise it
    // releases in the same cycle and plain round-robin applies.
    owner_busy = (mode_q == LOCKED) && (owner_q ? rq1_req : rq0_req);
    if (!reset) begin
      if (owner_busy) begin
        gnt0 = !owner_q;
        gnt1 = owner_q;
      end else if (rq0_req && rq1_req) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = rq0_req;
        gnt1 = rq1_req;
      end
    end
  end

  // Winner payload mux and address legality.
  always_comb begin
    accept    = gnt0 | gnt1;
    win       = gnt1;
    win_wr    = win ? rq1_wr    : rq0_wr;
    win_lock  = win ? rq1_lock  : rq0_lock;
    win_addr  = win ? rq1_addr  : rq0_addr;
    win_wdata = win ? rq1_wdata : rq0_wdata;
    legal     = (win_addr < ADDR_W'(MEM_BYTES)) && (win_addr[1:0] == 2'b00);
  end

  assign rq0_gnt   = gnt0;
  assign rq1_gnt   = gnt1;
  assign mem_rd    = accept && !win_wr && legal;
  assign mem_wr    = accept &&  win_wr && legal;
  assign mem_addr  = accept ? win_addr  : '0;
  assign mem_wdata = accept ? win_wdata : '0;

  // Next-state: lock/burst tracking and response capture.
  always_comb begin
    mode_d    = mode_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    if (mode_q == LOCKED && !owner_busy) begin
      mode_d = ARB;
      cnt_d  = '0;
    end

    if (accept) begin
      last_d = win;
      if (owner_busy) begin
        // Owner beat: keep going unless it drops lock or hits the burst cap.
        if (win_lock && (cnt_q + CNT_W'(1)) != CNT_W'(MAX_BURST)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          mode_d = ARB;
          cnt_d  = '0;
        end
      end else if (win_lock) begin
        mode_d  = LOCKED;
        owner_d = win;
        cnt_d   = CNT_W'(1);
      end

      if (win) begin
        rvalid1_d = 1'b1;
        err1_d    = !legal;
        if (!legal)       rdata1_d = '0;
        else if (!win_wr) rdata1_d = mem_rdata;
      end else begin
        rvalid0_d = 1'b1;
        err0_d    = !legal;
        if (!legal)       rdata0_d = '0;
        else if (!win_wr) rdata0_d = mem_rdata;
      end
    end
  end

  // State registers; last resets to 1 so rq0 wins the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= ARB;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      mode_q    <= mode_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rq0_rvalid = rvalid0_q;
  assign rq1_rvalid = rvalid1_q;
  assign rq0_err    = err0_q;
  assign rq1_err    = err1_q;
  assign rq0_rdata  = rdata0_q;
  assign rq1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rq0_req, rq0_wr, rq0_lock, rq1_req, rq1_wr, rq1_lock;
  logic [31:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
  logic        rq0_gnt, rq0_rvalid, rq0_err, rq1_gnt, rq1_rvalid, rq1_err;
  logic [31:0] rq0_rdata, rq1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .rq0_req(rq0_req), .rq0_wr(rq0_wr), .rq0_lock(rq0_lock),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq1_req(rq1_req), .rq1_wr(rq1_wr), .rq1_lock(rq1_lock),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq0_gnt(rq0_gnt), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata), .rq0_err(rq0_err),
    .rq1_gnt(rq1_gnt), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata), .rq1_err(rq1_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rq0_req = 1'b0; rq0_wr = 1'b0; rq0_lock = 1'b0; rq0_addr = '0; rq0_wdata = '0;
    rq1_req = 1'b0; rq1_wr = 1'b0; rq1_lock = 1'b0; rq1_addr = '0; rq1_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4]   = 32'hDEADBEEF;
    mem[5]   = 32'h11112222;
    mem[8]   = 32'h12345678;
    mem[255] = 32'hCAFEF00D;

    // Reset holds grants and responses low even with both requesting.
    reset = 1'b1;
    idle();
    rq0_req = 1'b1; rq1_req = 1'b1;
    #1;
    chk("rst_gnt0", rq0_gnt, 0);
    chk("rst_gnt1", rq1_gnt, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_rvalid0", rq0_rvalid, 0);
    chk("rst_rdata0", rq0_rdata, 0);
    chk("rst_rdata1", rq1_rdata, 0);
    cyc(); cyc();
    idle();
    reset = 1'b0;

    // 1: single read
    rq0_req = 1'b1; rq0_addr = 32'h10;
    #1;
    chk("t1_gnt0", rq0_gnt, 1);
    chk("t1_gnt1", rq1_gnt, 0);
    chk("t1_mem_rd", mem_rd, 1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    cyc();
    idle();
    chk("t1_rvalid0", rq0_rvalid, 1);
    chk("t1_rdata0", rq0_rdata, 32'hDEADBEEF);
    chk("t1_err0", rq0_err, 0);
    chk("t1_rvalid1", rq1_rvalid, 0);
    cyc();
    chk("t1_pulse_end", rq0_rvalid, 0);

    // 2: round-robin from a fresh reset
    reset = 1'b1;
    #1;
    cyc();
    reset = 1'b0;
    rq0_req = 1'b1; rq0_addr = 32'h10;
    rq1_req = 1'b1; rq1_addr = 32'h14;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_gnt0", rq0_gnt, 32'((i % 2) == 0));
      chk("t2_gnt1", rq1_gnt, 32'((i % 2) == 1));
      cyc();
      chk("t2_rvalid0", rq0_rvalid, 32'((i % 2) == 0));
      chk("t2_rvalid1", rq1_rvalid, 32'((i % 2) == 1));
      if ((i % 2) == 0) chk("t2_rdata0", rq0_rdata, 32'hDEADBEEF);
      else              chk("t2_rdata1", rq1_rdata, 32'h11112222);
    end
    idle();
    cyc();

    // 3: rq1 locked write burst, forced release after 8 beats
    for (int b = 0; b < 9; b++) begin
      rq1_req = 1'b1; rq1_wr = 1'b1; rq1_lock = 1'b1;
      rq1_addr = 32'(4 * b); rq1_wdata = 32'hA0 + 32'(b);
      rq0_req = (b != 0); rq0_addr = 32'h10;
      #1;
      if (b < 8) begin
        chk("t3_gnt1", rq1_gnt, 1);
        chk("t3_gnt0", rq0_gnt, 0);
        chk("t3_mem_wr", mem_wr, 1);
      end else begin
        chk("t3_rel_gnt0", rq0_gnt, 1);
        chk("t3_rel_gnt1", rq1_gnt, 0);
      end
      cyc();
      if (b < 8) begin
        chk("t3_rvalid1", rq1_rvalid, 1);
        chk("t3_err1", rq1_err, 0);
      end else begin
        chk("t3_rvalid0", rq0_rvalid, 1);
        chk("t3_rdata0", rq0_rdata, 32'hA4);
      end
    end
    idle();
    for (int k = 0; k < 8; k++) chk("t3_mem", mem[k], 32'hA0 + 32'(k));
    chk("t3_mem_untouched", mem[8], 32'h12345678);

    // 4: rq0 locked beats then unlock; rq1 waits and wins the 5th cycle
    for (int b = 0; b < 5; b++) begin
      rq0_req = 1'b1; rq0_addr = 32'h20; rq0_lock = (b < 3);
      rq1_req = (b != 0); rq1_addr = 32'h24;
      #1;
      chk("t4_gnt0", rq0_gnt, 32'(b != 4));
      chk("t4_gnt1", rq1_gnt, 32'(b == 4));
      cyc();
    end
    idle();
    chk("t4_rvalid1", rq1_rvalid, 1);
    chk("t4_rdata0", rq0_rdata, 32'h12345678);

    // 5: illegal addresses and the top legal word
    rq0_req = 1'b1; rq0_addr = 32'h12;
    #1;
    chk("t5_rd_gnt0", rq0_gnt, 1);
    chk("t5_rd_mem_rd", mem_rd, 0);
    cyc();
    idle();
    chk("t5_rd_rvalid0", rq0_rvalid, 1);
    chk("t5_rd_err0", rq0_err, 1);
    chk("t5_rd_rdata0", rq0_rdata, 0);

    rq0_req = 1'b1; rq0_wr = 1'b1; rq0_addr = 32'h400; rq0_wdata = 32'h55;
    #1;
    chk("t5_wr_gnt0", rq0_gnt, 1);
    chk("t5_wr_mem_wr", mem_wr, 0);
    cyc();
    idle();
    chk("t5_wr_rvalid0", rq0_rvalid, 1);
    chk("t5_wr_err0", rq0_err, 1);
    chk("t5_wr_mem0", mem[0], 32'hA0);

    rq1_req = 1'b1; rq1_addr = 32'h3FC;
    #1;
    chk("t5_top_mem_rd", mem_rd, 1);
    cyc();
    idle();
    chk("t5_top_rvalid1", rq1_rvalid, 1);
    chk("t5_top_err1", rq1_err, 0);
    chk("t5_top_rdata1", rq1_rdata, 32'hCAFEF00D);

    // 6: reset during beat 3 of an rq1 locked burst
    rq1_req = 1'b1; rq1_wr = 1'b1; rq1_lock = 1'b1; rq1_addr = 32'h40; rq1_wdata = 32'h77;
    #1;
    chk("t6_b1_gnt1", rq1_gnt, 1);
    cyc();
    rq0_req = 1'b1; rq0_addr = 32'h10; rq1_addr = 32'h44;
    #1;
    chk("t6_b2_gnt1", rq1_gnt, 1);
    cyc();
    rq1_addr = 32'h48;
    #1;
    chk("t6_b3_gnt1", rq1_gnt, 1);
    chk("t6_b3_rvalid1", rq1_rvalid, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_gnt1", rq1_gnt, 0);
    chk("t6_rst_gnt0", rq0_gnt, 0);
    chk("t6_rst_mem_wr", mem_wr, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    chk("t6_rst_rvalid1", rq1_rvalid, 0);
    chk("t6_rst_rdata1", rq1_rdata, 0);
    cyc();
    reset = 1'b0;
    rq1_lock = 1'b0; rq1_wr = 1'b0;
    #1;
    chk("t6_post_gnt0", rq0_gnt, 1);
    chk("t6_post_gnt1", rq1_gnt, 0);
    chk("t6_no_write", mem[18], 0);
    cyc();
    idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
